top_two_selector: RTL and testbench
===================================

Name: top_two_selector

Overview:
- Sequential, parametrised successor to the five-input two-largest finder.
- Accepts N unsigned W-bit samples one per cycle over a valid/ready stream after a start strobe.
- Tracks the largest and second-largest values and their 1-based arrival indices, then pulses load so the downstream register file captures them.
- Sits between the operand entry logic and the register file.

Parameters:
- W, 4, sample width in bits (W >= 1)
- N, 5, samples per sort job (N >= 1)
- IW, $clog2(N+1), index width (derived localparam; index 0 means "none")

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- St  in  1  start strobe; sampled in IDLE only
- din_valid  in  1  sample present on din
- din  in  W  unsigned sample
- din_ready  out  1  block accepts din this cycle
- L  out  W  largest value
- L2  out  W  second-largest value
- idx1  out  IW  1-based arrival index of L
- idx2  out  IW  1-based arrival index of L2 (0 if none)
- sec_valid  out  1  L2/idx2 meaningful (N >= 2)
- busy  out  1  job in progress
- load  out  1  one-cycle pulse: results final

Behaviour:
- Clock is clk; reset is asynchronous and active-high on rst. These are fixed.
- Reset: state=IDLE and cnt=0. All outputs are 0: L, L2, idx1, idx2, sec_valid, busy, load, din_ready. Reset takes effect immediately when asserted, including mid-job. The partial job is discarded and no load is issued.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: din_ready=0 and busy=0. Results from the previous job hold. When St=1, clear L, L2, idx1, idx2, sec_valid, and cnt to 0, then go to COLLECT next cycle.
  - COLLECT: din_ready=1 and busy=1. A sample is accepted when din_valid && din_ready. On each accept, cnt increments and the sample takes index k=cnt+1. When the accept with k==N occurs, go to DONE.
  - DONE: lasts exactly one cycle. load=1 and busy=0. Outputs now hold the final result. Return to IDLE.
- Update rule on accepting sample x with index k:
  - k==1: L=x, idx1=1.
  - Else if x > L (strict): L2=L, idx2=idx1, L=x, idx1=k, sec_valid=1.
  - Else if !sec_valid or x > L2 (strict): L2=x, idx2=k, sec_valid=1.
  - Else: no change.
- Tie rules:
  - Equal values keep the earlier index for both L and L2.
  - A duplicate of the maximum becomes L2, so L2 may equal L.
- Comparisons are unsigned, full W bits, with no overflow path. cnt is IW bits wide and never exceeds N.
- Latency: load asserts in the cycle after the Nth accepted sample. Minimum job length is N+2 cycles from St (St cycle, N accepts, DONE).
- Gaps: din_valid=0 cycles in COLLECT are stalls. State holds and there is no timeout.
- St is ignored in COLLECT and DONE; there is no restart or abort. St held high continuously starts a new job on each return to IDLE.
- din is ignored when din_ready=0.
- N==1: load after one accept, with sec_valid=0, L2=0, idx2=0.
- Outputs are registered, with no combinational path from din to L/L2.

Decomposition:
- Shared package top_two_pkg holds:
  - the state enum type (IDLE, COLLECT, DONE);
  - the function idx_width(N) returning $clog2(N+1);
  - the constant IDX_NONE=0.
- One natural sub-module, top_two_update: a purely combinational next-value unit implementing the update rule. It takes (x, k, L, L2, idx1, idx2, sec_valid) and returns next values. The top level holds the FSM, counter and registers. top_two_update is reusable for a future top-K chain.

Test Plan:
- Defaults, St then stream 3,9,4,9,1 with no gaps -> load one cycle after 5th accept; L=9, idx1=2, L2=9, idx2=4, sec_valid=1.
- Defaults, stream 0,0,0,0,0 -> L=0, idx1=1, L2=0, idx2=2, sec_valid=1 (zero handled via sec_valid, not magnitude).
- Defaults, stream 15,2,7,14,14 with din_valid low for 3 cycles between samples 2 and 3 -> stalls hold state; busy=1 throughout; L=15, idx1=1, L2=14, idx2=4; St pulses during COLLECT have no effect.
- Defaults, assert rst after 3 accepts -> all outputs 0 immediately, no load; a following St with stream 1,2,3,4,5 gives L=5, idx1=5, L2=4, idx2=4.
- N=1, W=8, stream 200 -> L=200, idx1=1, sec_valid=0, L2=0, idx2=0, load one cycle after accept.
- N=8, W=6, stream 10,63,5,62,63,0,1,2 -> L=63, idx1=2, L2=63, idx2=5; results hold through IDLE until next St.

Source files
------------

// File: rtl/top_two_pkg.sv
// ---------------------------------------------------------------------------
// top_two_pkg
// Shared definitions for the sequential two-largest selector.
//   state_t    : FSM encoding used by top_two_selector (IDLE, COLLECT, DONE)
//   IDX_NONE   : index value meaning "no sample recorded"
//   idx_width  : width needed to hold 1-based indices 0..n
// ---------------------------------------------------------------------------
package top_two_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int IDX_NONE = 0;

    // Index 0 is reserved for "none", so n samples need room for 0..n.
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/top_two_update.sv
// ---------------------------------------------------------------------------
// top_two_update
// Purely combinational next-value unit for a running top-two tracker.
// Given the accepted sample x with 1-based index k and the current
// tracker contents, produces the tracker contents after the update.
// Ports:
//   x, k                        : accepted sample and its arrival index
//   cur_l, cur_idx1             : current largest value and its index
//   cur_l2, cur_idx2            : current second-largest value and its index
//   cur_sec_valid               : cur_l2/cur_idx2 hold a real sample
//   next_*                      : updated versions of the above
// ---------------------------------------------------------------------------
module top_two_update
    import top_two_pkg::*;
#(
    parameter int W  = 4,
    parameter int IW = 3
) (
    input  logic [W-1:0]  x,
    input  logic [IW-1:0] k,
    input  logic [W-1:0]  cur_l,
    input  logic [W-1:0]  cur_l2,
    input  logic [IW-1:0] cur_idx1,
    input  logic [IW-1:0] cur_idx2,
    input  logic          cur_sec_valid,
    output logic [W-1:0]  next_l,
    output logic [W-1:0]  next_l2,
    output logic [IW-1:0] next_idx1,
    output logic [IW-1:0] next_idx2,
    output logic          next_sec_valid
);

    // Strict comparisons keep the earlier index on ties. A duplicate of the
    // maximum falls through to the second branch, so L2 may equal L. The
    // second slot is filled via sec_valid rather than by magnitude so that
    // zero-valued samples are still recorded.
    always_comb begin
        next_l         = cur_l;
        next_l2        = cur_l2;
        next_idx1      = cur_idx1;
        next_idx2      = cur_idx2;
        next_sec_valid = cur_sec_valid;
        if (k == IW'(1)) begin
            next_l    = x;
            next_idx1 = k;
        end else if (x > cur_l) begin
            next_l2        = cur_l;
            next_idx2      = cur_idx1;
            next_l         = x;
            next_idx1      = k;
            next_sec_valid = 1'b1;
        end else if (!cur_sec_valid || (x > cur_l2)) begin
            next_l2        = x;
            next_idx2      = k;
            next_sec_valid = 1'b1;
        end
    end

endmodule

// File: rtl/top_two_selector.sv
// ---------------------------------------------------------------------------
// top_two_selector
// Collects N unsigned W-bit samples over a valid/ready stream after a start
// strobe, tracks the two largest values with their 1-based arrival indices,
// and pulses load for one cycle once the results are final.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   St              : start strobe, only honoured in IDLE
//   din_valid, din  : sample stream input
//   din_ready       : high while collecting samples
//   L, idx1         : largest value and its index
//   L2, idx2        : second-largest value and its index (0 if none)
//   sec_valid       : L2/idx2 hold a real sample
//   busy            : job in progress (COLLECT)
//   load            : one-cycle pulse in DONE, results are final
// ---------------------------------------------------------------------------
module top_two_selector
    import top_two_pkg::*;
#(
    parameter  int W  = 4,
    parameter  int N  = 5,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          St,
    input  logic          din_valid,
    input  logic [W-1:0]  din,
    output logic          din_ready,
    output logic [W-1:0]  L,
    output logic [W-1:0]  L2,
    output logic [IW-1:0] idx1,
    output logic [IW-1:0] idx2,
    output logic          sec_valid,
    output logic          busy,
    output logic          load
);

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] cnt;
    logic [IW-1:0] k;
    logic          accept;
    logic          last;

    logic [W-1:0]  upd_l;
    logic [W-1:0]  upd_l2;
    logic [IW-1:0] upd_idx1;
    logic [IW-1:0] upd_idx2;
    logic          upd_sec_valid;

    assign accept = din_valid && din_ready;
    assign k      = cnt + IW'(1);
    assign last   = accept && (k == IW'(N));

    top_two_update #(
        .W  (W),
        .IW (IW)
    ) u_update (
        .x              (din),
        .k              (k),
        .cur_l          (L),
        .cur_l2         (L2),
        .cur_idx1       (idx1),
        .cur_idx2       (idx2),
        .cur_sec_valid  (sec_valid),
        .next_l         (upd_l),
        .next_l2        (upd_l2),
        .next_idx1      (upd_idx1),
        .next_idx2      (upd_idx2),
        .next_sec_valid (upd_sec_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/status decode. All strobes are decoded from
    // the state register only, so they carry no path from the inputs.
    always_comb begin
        next_state = state;
        din_ready  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (St) begin
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                load       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Result registers and sample counter. A start clears the previous
    // job's results; otherwise results hold until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            L         <= '0;
            L2        <= '0;
            idx1      <= IW'(IDX_NONE);
            idx2      <= IW'(IDX_NONE);
            sec_valid <= 1'b0;
        end else if ((state == IDLE) && St) begin
            cnt       <= '0;
            L         <= '0;
            L2        <= '0;
            idx1      <= IW'(IDX_NONE);
            idx2      <= IW'(IDX_NONE);
            sec_valid <= 1'b0;
        end else if (accept) begin
            cnt       <= k;
            L         <= upd_l;
            L2        <= upd_l2;
            idx1      <= upd_idx1;
            idx2      <= upd_idx2;
            sec_valid <= upd_sec_valid;
        end
    end

endmodule

// File: tb/tb_top_two_selector.sv
// ---------------------------------------------------------------------------
// tb_top_two_selector
// Directed bench for top_two_selector. Three instances cover the default
// configuration (W=4, N=5), the single-sample job (W=8, N=1) and a longer
// job (W=6, N=8). All drive and sample activity happens 1 time unit after
// the rising clock edge.
// ---------------------------------------------------------------------------
module tb_top_two_selector;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance A: W=4, N=5 (IW=3)
    logic       st_a, valid_a, ready_a, sec_a, busy_a, load_a;
    logic [3:0] din_a, l_a, l2_a;
    logic [2:0] idx1_a, idx2_a;

    // Instance B: W=8, N=1 (IW=1)
    logic       st_b, valid_b, ready_b, sec_b, busy_b, load_b;
    logic [7:0] din_b, l_b, l2_b;
    logic [0:0] idx1_b, idx2_b;

    // Instance C: W=6, N=8 (IW=4)
    logic       st_c, valid_c, ready_c, sec_c, busy_c, load_c;
    logic [5:0] din_c, l_c, l2_c;
    logic [3:0] idx1_c, idx2_c;

    int checks = 0;
    int errors = 0;

    top_two_selector #(.W(4), .N(5)) dut_a (
        .clk(clk), .rst(rst), .St(st_a), .din_valid(valid_a), .din(din_a),
        .din_ready(ready_a), .L(l_a), .L2(l2_a), .idx1(idx1_a), .idx2(idx2_a),
        .sec_valid(sec_a), .busy(busy_a), .load(load_a)
    );

    top_two_selector #(.W(8), .N(1)) dut_b (
        .clk(clk), .rst(rst), .St(st_b), .din_valid(valid_b), .din(din_b),
        .din_ready(ready_b), .L(l_b), .L2(l2_b), .idx1(idx1_b), .idx2(idx2_b),
        .sec_valid(sec_b), .busy(busy_b), .load(load_b)
    );

    top_two_selector #(.W(6), .N(8)) dut_c (
        .clk(clk), .rst(rst), .St(st_c), .din_valid(valid_c), .din(din_c),
        .din_ready(ready_c), .L(l_c), .L2(l2_c), .idx1(idx1_c), .idx2(idx2_c),
        .sec_valid(sec_c), .busy(busy_c), .load(load_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkResultA(input string tag, input int l, input int i1,
                                input int l2, input int i2, input int sec);
        checkOutput({tag, " L"},         32'(l_a),    32'(l));
        checkOutput({tag, " idx1"},      32'(idx1_a), 32'(i1));
        checkOutput({tag, " L2"},        32'(l2_a),   32'(l2));
        checkOutput({tag, " idx2"},      32'(idx2_a), 32'(i2));
        checkOutput({tag, " sec_valid"}, 32'(sec_a),  32'(sec));
    endtask

    task automatic checkStatusA(input string tag, input int ready, input int bsy,
                                input int ld);
        checkOutput({tag, " din_ready"}, 32'(ready_a), 32'(ready));
        checkOutput({tag, " busy"},      32'(busy_a),  32'(bsy));
        checkOutput({tag, " load"},      32'(load_a),  32'(ld));
    endtask

    // Present one sample to instance A and let the clock edge accept it.
    task automatic applyStimulus(input logic [3:0] v);
        din_a   = v;
        valid_a = 1'b1;
        tick();
    endtask

    task automatic startA();
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
    endtask

    logic [5:0] vec_c [8];

    initial begin
        rst = 1'b1;
        st_a = 0; valid_a = 0; din_a = '0;
        st_b = 0; valid_b = 0; din_b = '0;
        st_c = 0; valid_c = 0; din_c = '0;
        vec_c = '{6'd10, 6'd63, 6'd5, 6'd62, 6'd63, 6'd0, 6'd1, 6'd2};

        tick();
        tick();
        checkResultA("reset", 0, 0, 0, 0, 0);
        checkStatusA("reset", 0, 0, 0);
        rst = 1'b0;
        tick();
        checkStatusA("idle", 0, 0, 0);

        // Job 1: 3,9,4,9,1 back to back; duplicate maximum becomes L2.
        $display("[TB] job 1: 3,9,4,9,1");
        startA();
        checkStatusA("job1 collect", 1, 1, 0);
        applyStimulus(4'd3);
        applyStimulus(4'd9);
        applyStimulus(4'd4);
        applyStimulus(4'd9);
        checkStatusA("job1 before last", 1, 1, 0);
        applyStimulus(4'd1);
        valid_a = 1'b0;
        checkStatusA("job1 done", 0, 0, 1);
        checkResultA("job1", 9, 2, 9, 4, 1);
        tick();
        checkStatusA("job1 idle", 0, 0, 0);
        checkResultA("job1 hold", 9, 2, 9, 4, 1);

        // Job 2: all zeros; start clears previous results.
        $display("[TB] job 2: all zeros");
        startA();
        checkResultA("job2 cleared", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'd0);
        end
        valid_a = 1'b0;
        checkStatusA("job2 done", 0, 0, 1);
        checkResultA("job2", 0, 1, 0, 2, 1);
        tick();

        // Job 3: stall between samples 2 and 3 with St pulses during COLLECT.
        $display("[TB] job 3: stalls");
        startA();
        applyStimulus(4'd15);
        applyStimulus(4'd2);
        valid_a = 1'b0;
        din_a   = 4'd9;
        for (int i = 0; i < 3; i++) begin
            st_a = 1'b1;
            tick();
            checkOutput("job3 stall busy", 32'(busy_a), 32'd1);
        end
        st_a = 1'b0;
        checkResultA("job3 stall hold", 15, 1, 2, 2, 1);
        applyStimulus(4'd7);
        applyStimulus(4'd14);
        applyStimulus(4'd14);
        valid_a = 1'b0;
        checkStatusA("job3 done", 0, 0, 1);
        checkResultA("job3", 15, 1, 14, 4, 1);
        tick();
        checkStatusA("job3 idle", 0, 0, 0);

        // Job 4: reset after three accepts discards the job immediately.
        $display("[TB] job 4: reset mid-job");
        startA();
        applyStimulus(4'd5);
        applyStimulus(4'd6);
        applyStimulus(4'd7);
        valid_a = 1'b0;
        checkResultA("job4 partial", 7, 3, 6, 2, 1);
        rst = 1'b1;
        #1;
        checkResultA("job4 async reset", 0, 0, 0, 0, 0);
        checkStatusA("job4 async reset", 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        checkStatusA("job4 after reset", 0, 0, 0);
        startA();
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        applyStimulus(4'd3);
        applyStimulus(4'd4);
        applyStimulus(4'd5);
        valid_a = 1'b0;
        checkStatusA("job4 done", 0, 0, 1);
        checkResultA("job4", 5, 5, 4, 4, 1);
        tick();

        // Job 5: N=1 instance, single sample, no second result.
        $display("[TB] job 5: N=1");
        st_b = 1'b1;
        tick();
        st_b = 1'b0;
        checkOutput("n1 busy", 32'(busy_b), 32'd1);
        checkOutput("n1 load early", 32'(load_b), 32'd0);
        din_b   = 8'd200;
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        checkOutput("n1 load", 32'(load_b), 32'd1);
        checkOutput("n1 L", 32'(l_b), 32'd200);
        checkOutput("n1 idx1", 32'(idx1_b), 32'd1);
        checkOutput("n1 sec_valid", 32'(sec_b), 32'd0);
        checkOutput("n1 L2", 32'(l2_b), 32'd0);
        checkOutput("n1 idx2", 32'(idx2_b), 32'd0);
        tick();
        checkOutput("n1 load cleared", 32'(load_b), 32'd0);

        // Job 6: N=8 instance; results hold in IDLE until next start.
        $display("[TB] job 6: N=8");
        st_c = 1'b1;
        tick();
        st_c = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din_c   = vec_c[i];
            valid_c = 1'b1;
            tick();
        end
        valid_c = 1'b0;
        checkOutput("n8 load", 32'(load_c), 32'd1);
        checkOutput("n8 L", 32'(l_c), 32'd63);
        checkOutput("n8 idx1", 32'(idx1_c), 32'd2);
        checkOutput("n8 L2", 32'(l2_c), 32'd63);
        checkOutput("n8 idx2", 32'(idx2_c), 32'd5);
        checkOutput("n8 sec_valid", 32'(sec_c), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checkOutput("n8 hold load", 32'(load_c), 32'd0);
        checkOutput("n8 hold L2", 32'(l2_c), 32'd63);
        checkOutput("n8 hold idx2", 32'(idx2_c), 32'd5);
        st_c = 1'b1;
        tick();
        st_c = 1'b0;
        checkOutput("n8 restart L", 32'(l_c), 32'd0);
        checkOutput("n8 restart busy", 32'(busy_c), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
